// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter:
// FSM state encoding, funct3 size codes and size-decoding helpers.
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_IF = 2'd1;
   localparam logic [1:0] ST_BUSY_LS = 2'd2;
   localparam logic [1:0] ST_ERR     = 2'd3;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Any code outside B/H/BU/HU behaves as a full word access.
   function automatic logic [2:0] norm_ctrl(input logic [2:0] ctrl);
      logic [2:0] res;
      case (ctrl)
         SZ_B, SZ_H, SZ_BU, SZ_HU: res = ctrl;
         default:                  res = SZ_W;
      endcase
      return res;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] offset);
      logic res;
      case (norm_ctrl(ctrl))
         SZ_H, SZ_HU: res = offset[0];
         SZ_W:        res = |offset;
         default:     res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and
// load lane extraction with sign or zero extension.
module mem_lane_align
   import mem_arbiter_pkg::*;
(
   input  logic [2:0]  ctrl,
   input  logic [1:0]  offset,
   input  logic        we,
   input  logic [31:0] wdata_raw,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [2:0]  size_c;
   logic [31:0] shifted;
   logic [3:0]  be_st;

   always_comb begin
      size_c     = norm_ctrl(ctrl);
      shifted    = rdata_raw >> {offset, 3'b000};
      be_st      = 4'b1111;
      wdata_lane = wdata_raw;
      rdata_ext  = rdata_raw;
      case (size_c)
         SZ_B: begin
            be_st      = 4'b0001 << offset;
            wdata_lane = {4{wdata_raw[7:0]}};
            rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
         end
         SZ_BU: begin
            be_st      = 4'b0001 << offset;
            wdata_lane = {4{wdata_raw[7:0]}};
            rdata_ext  = {24'h000000, shifted[7:0]};
         end
         SZ_H: begin
            be_st      = 4'b0011 << offset;
            wdata_lane = {2{wdata_raw[15:0]}};
            rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
         end
         SZ_HU: begin
            be_st      = 4'b0011 << offset;
            wdata_lane = {2{wdata_raw[15:0]}};
            rdata_ext  = {16'h0000, shifted[15:0]};
         end
         default: begin
            be_st      = 4'b1111;
            wdata_lane = wdata_raw;
            rdata_ext  = rdata_raw;
         end
      endcase
      be = we ? be_st : 4'b1111;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and
// load/store, with load/store priority and a fetch anti-starvation limit.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_valid,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [2:0]  ls_ctrl,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_gnt,
   output logic        ls_valid,
   output logic        ls_misalign,
   output logic [31:0] rsp_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [29:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [2:0]    ctrl_q, ctrl_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          if_valid_q, if_valid_d;
   logic          ls_valid_q, ls_valid_d;
   logic          misalign_q, misalign_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          fetch_win;
   logic          busy;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wdata;
   logic [31:0]   lane_rdata;
   logic          unused_addr_bits;

   mem_lane_align u_lane (
      .ctrl       (ctrl_q),
      .offset     (off_q),
      .we         (we_q),
      .wdata_raw  (wdata_q),
      .rdata_raw  (mem_rdata),
      .be         (lane_be),
      .wdata_lane (lane_wdata),
      .rdata_ext  (lane_rdata)
   );

   // Grants are combinational from IDLE and forced low while reset is held.
   always_comb begin
      unused_addr_bits = ^if_addr[1:0];
      fetch_win = if_req && (!ls_req || (starve_q == LIMIT_C));
      if_gnt    = (state_q == ST_IDLE) && !rst && fetch_win;
      ls_gnt    = (state_q == ST_IDLE) && !rst && ls_req && !fetch_win;
   end

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      addr_d     = addr_q;
      we_d       = we_q;
      ctrl_d     = ctrl_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      if_valid_d = 1'b0;
      ls_valid_d = 1'b0;
      misalign_d = 1'b0;
      rdata_d    = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req && !if_gnt && (starve_q != LIMIT_C)) begin
               starve_d = starve_q + SW'(1);
            end
            if (if_gnt) begin
               starve_d = '0;
               state_d  = ST_BUSY_IF;
               addr_d   = if_addr[31:2];
               we_d     = 1'b0;
               ctrl_d   = SZ_W;
               off_d    = 2'b00;
               wdata_d  = '0;
            end else if (ls_gnt) begin
               addr_d  = ls_addr[31:2];
               we_d    = ls_we;
               ctrl_d  = norm_ctrl(ls_ctrl);
               off_d   = ls_addr[1:0];
               wdata_d = ls_wdata;
               // Misaligned accesses report in the ERR cycle itself.
               if (is_misaligned(ls_ctrl, ls_addr[1:0])) begin
                  state_d    = ST_ERR;
                  ls_valid_d = 1'b1;
                  misalign_d = 1'b1;
                  rdata_d    = '0;
               end else begin
                  state_d = ST_BUSY_LS;
               end
            end
         end
         ST_BUSY_IF: begin
            if (mem_ready) begin
               state_d    = ST_IDLE;
               if_valid_d = 1'b1;
               rdata_d    = mem_rdata;
            end
         end
         ST_BUSY_LS: begin
            if (mem_ready) begin
               state_d    = ST_IDLE;
               ls_valid_d = 1'b1;
               rdata_d    = we_q ? '0 : lane_rdata;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         starve_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         ctrl_q     <= SZ_W;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         if_valid_q <= 1'b0;
         ls_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         ctrl_q     <= ctrl_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         if_valid_q <= if_valid_d;
         ls_valid_q <= ls_valid_d;
         misalign_q <= misalign_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      busy        = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_LS);
      mem_en      = busy;
      mem_we      = (state_q == ST_BUSY_LS) && we_q;
      mem_addr    = busy ? {addr_q, 2'b00} : '0;
      mem_be      = busy ? lane_be : '0;
      mem_wdata   = ((state_q == ST_BUSY_LS) && we_q) ? lane_wdata : '0;
      if_valid    = if_valid_q;
      ls_valid    = ls_valid_q;
      ls_misalign = misalign_q;
      rsp_rdata   = rdata_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed corner cases plus
// randomized single transactions checked against a lane/size model.
module tb_mem_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_valid;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [2:0]  ls_ctrl = 3'b010;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_gnt, ls_valid, ls_misalign;
   logic [31:0] rsp_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   int total = 0;
   int bad = 0;

   logic [106:0] all_out;
   assign all_out = {if_gnt, ls_gnt, if_valid, ls_valid, ls_misalign, rsp_rdata,
                     mem_en, mem_we, mem_addr, mem_wdata, mem_be};

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_ctrl(ls_ctrl), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_misalign(ls_misalign),
      .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          gw;
      int          lat;
      logic        en_seen;
      logic        held;
      logic        other_valid;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] addr;
      logic [31:0] rsp;
      logic        we;
      logic        mis;
   } xfer_t;

   // Reference model: access width in bytes from the funct3 code.
   function automatic int m_size(input logic [2:0] c);
      case (c)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic m_mis(input logic [2:0] c, input logic [31:0] a);
      int s = m_size(c);
      return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [3:0] m_be(input logic we, input logic [2:0] c, input logic [31:0] a);
      int s = m_size(c);
      int v;
      if (!we) return 4'hF;
      v = ((1 << s) - 1) << a[1:0];
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] w);
      int s = m_size(c);
      if (s == 1) return {4{w[7:0]}};
      if (s == 2) return {2{w[15:0]}};
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] rd);
      int s = m_size(c);
      logic [31:0] v, mask;
      v = rd >> (8 * a[1:0]);
      mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
      v = v & mask;
      if (c[2] == 1'b0 && s < 4 && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   // Drives one request (entered/exited at posedge+1), acts as memory, records observations.
   task automatic do_xfer(input logic is_if, input logic we, input logic [2:0] ctrl,
                          input logic [31:0] addr, input logic [31:0] wd, input int dly,
                          input logic [31:0] rd, output xfer_t r);
      r.gw = -1; r.lat = -1; r.en_seen = 0; r.held = 1; r.other_valid = 0;
      r.be = '0; r.wdata = '0; r.addr = '0; r.rsp = '0; r.we = 0; r.mis = 0;
      if (is_if) begin
         if_req = 1; if_addr = addr;
      end else begin
         ls_req = 1; ls_we = we; ls_ctrl = ctrl; ls_addr = addr; ls_wdata = wd;
      end
      for (int i = 0; i < 20 && r.gw < 0; i++) begin
         #1;
         if (is_if ? if_gnt : ls_gnt) r.gw = i;
         @(posedge clk); #1;
      end
      if_req = 0; ls_req = 0;
      if (r.gw >= 0) begin
         mem_rdata = rd;
         for (int k = 1; k <= 30 && r.lat < 0; k++) begin
            mem_ready = (k == dly + 1);
            #1;
            if (mem_en) begin
               if (!r.en_seen) begin
                  r.be = mem_be; r.wdata = mem_wdata; r.addr = mem_addr; r.we = mem_we;
               end else if (mem_be !== r.be || mem_wdata !== r.wdata || mem_addr !== r.addr || mem_we !== r.we) begin
                  r.held = 0;
               end
               r.en_seen = 1;
            end
            if (is_if ? ls_valid : if_valid) r.other_valid = 1;
            if (is_if ? if_valid : ls_valid) begin
               r.lat = k; r.rsp = rsp_rdata; r.mis = ls_misalign;
            end
            @(posedge clk); #1;
         end
         mem_ready = 0;
      end
   endtask

   task automatic test_reset();
      rst = 1; if_req = 1; ls_req = 1; ls_ctrl = 3'b010;
      repeat (2) @(posedge clk);
      #2;
      total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
      if_req = 0; ls_req = 0;
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_lw_delay();
      xfer_t r;
      do_xfer(0, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, r);
      total++; if (r.gw !== 0) begin bad++; $display("FAIL lw_grant got=%0d exp=0", r.gw); end
      total++; if (r.lat !== 5) begin bad++; $display("FAIL lw_latency got=%0d exp=5", r.lat); end
      total++; if (r.rsp !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", r.rsp); end
      total++; if (r.be !== 4'hF || r.addr !== 32'h100 || r.we !== 0) begin bad++; $display("FAIL lw_mem got be=%b addr=%h we=%b exp be=1111 addr=100 we=0", r.be, r.addr, r.we); end
      total++; if (r.held !== 1) begin bad++; $display("FAIL lw_hold got=%b exp=1", r.held); end
   endtask

   task automatic test_lb();
      xfer_t r;
      do_xfer(0, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80000000, r);
      total++; if (r.rsp !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_sext got=%h exp=ffffff80", r.rsp); end
      total++; if (r.addr !== 32'h100 || r.lat !== 2) begin bad++; $display("FAIL lb_addr_lat got addr=%h lat=%0d exp addr=100 lat=2", r.addr, r.lat); end
      do_xfer(0, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80000000, r);
      total++; if (r.rsp !== 32'h00000080) begin bad++; $display("FAIL lbu_zext got=%h exp=00000080", r.rsp); end
   endtask

   task automatic test_sh();
      xfer_t r;
      do_xfer(0, 1, 3'b001, 32'h102, 32'h00001234, 0, 32'h0, r);
      total++; if (r.be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", r.be); end
      total++; if (r.wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%h exp=12341234", r.wdata); end
      total++; if (r.we !== 1 || r.lat !== 2 || r.mis !== 0) begin bad++; $display("FAIL sh_ctrl got we=%b lat=%0d mis=%b exp we=1 lat=2 mis=0", r.we, r.lat, r.mis); end
   endtask

   task automatic test_misalign();
      xfer_t r;
      do_xfer(0, 0, 3'b010, 32'h101, 32'h0, 0, 32'hFFFFFFFF, r);
      total++; if (r.en_seen !== 0) begin bad++; $display("FAIL mis_mem_en got=%b exp=0", r.en_seen); end
      total++; if (r.lat !== 1) begin bad++; $display("FAIL mis_latency got=%0d exp=1", r.lat); end
      total++; if (r.mis !== 1 || r.rsp !== 32'h0) begin bad++; $display("FAIL mis_rsp got mis=%b rdata=%h exp mis=1 rdata=0", r.mis, r.rsp); end
   endtask

   task automatic test_fetch();
      xfer_t r;
      do_xfer(1, 0, 3'b010, 32'h203, 32'h0, 2, 32'hCAFEF00D, r);
      total++; if (r.addr !== 32'h200 || r.be !== 4'hF || r.we !== 0) begin bad++; $display("FAIL if_mem got addr=%h be=%b we=%b exp addr=200 be=1111 we=0", r.addr, r.be, r.we); end
      total++; if (r.lat !== 4 || r.rsp !== 32'hCAFEF00D || r.other_valid !== 0) begin bad++; $display("FAIL if_rsp got lat=%0d rdata=%h other=%b exp lat=4 rdata=cafef00d other=0", r.lat, r.rsp, r.other_valid); end
   endtask

   task automatic test_starve();
      int ngr = 0;
      logic both = 0;
      logic exp_if;
      rst = 1; @(posedge clk); #1; rst = 0;
      if_req = 1; if_addr = 32'h20; ls_req = 1; ls_we = 0; ls_ctrl = 3'b010; ls_addr = 32'h10;
      mem_ready = 1; mem_rdata = 32'h11223344;
      for (int c = 0; c < 100 && ngr < 15; c++) begin
         #1;
         if (if_gnt && ls_gnt) both = 1;
         if (if_gnt || ls_gnt) begin
            exp_if = ((ngr % (LIMIT + 1)) == LIMIT);
            total++; if (if_gnt !== exp_if) begin bad++; $display("FAIL starve_grant%0d got if_gnt=%b exp=%b", ngr, if_gnt, exp_if); end
            ngr++;
         end
         @(posedge clk); #1;
      end
      if_req = 0; ls_req = 0;
      repeat (3) begin @(posedge clk); #1; end
      mem_ready = 0;
      total++; if (ngr !== 15) begin bad++; $display("FAIL starve_count got=%0d exp=15", ngr); end
      total++; if (both !== 0) begin bad++; $display("FAIL starve_dual_grant got=%b exp=0", both); end
   endtask

   task automatic test_reset_inflight();
      xfer_t r;
      logic seen = 0;
      ls_req = 1; ls_we = 0; ls_ctrl = 3'b010; ls_addr = 32'h40; mem_ready = 0;
      #1;
      total++; if (ls_gnt !== 1) begin bad++; $display("FAIL rstf_grant got=%b exp=1", ls_gnt); end
      @(posedge clk); #1;
      ls_req = 0;
      #1;
      total++; if (mem_en !== 1) begin bad++; $display("FAIL rstf_busy got=%b exp=1", mem_en); end
      rst = 1;
      #1;
      total++; if (all_out !== '0) begin bad++; $display("FAIL rstf_outputs got=%h exp=0", all_out); end
      mem_ready = 1; mem_rdata = 32'h99999999;
      repeat (2) begin
         @(posedge clk); #1;
         if (all_out !== '0) seen = 1;
      end
      rst = 0; mem_ready = 0;
      total++; if (seen !== 0) begin bad++; $display("FAIL rstf_quiet got=%b exp=0", seen); end
      do_xfer(0, 0, 3'b010, 32'h80, 32'h0, 0, 32'h0055AA11, r);
      total++; if (r.gw !== 0 || r.lat !== 2 || r.rsp !== 32'h0055AA11) begin bad++; $display("FAIL rstf_fresh got gw=%0d lat=%0d rdata=%h exp gw=0 lat=2 rdata=0055aa11", r.gw, r.lat, r.rsp); end
   endtask

   task automatic test_random();
      xfer_t r;
      logic is_if, we, mis;
      logic [2:0] ctrl;
      logic [31:0] addr, wd, rd, exp_rsp;
      int dly, exp_lat;
      for (int n = 0; n < 40; n++) begin
         is_if = ($urandom_range(0, 3) == 0);
         we = is_if ? 1'b0 : 1'($urandom_range(0, 1));
         ctrl = 3'($urandom_range(0, 7));
         addr = $urandom; wd = $urandom; rd = $urandom;
         dly = $urandom_range(0, 3);
         do_xfer(is_if, we, ctrl, addr, wd, dly, rd, r);
         mis = !is_if && m_mis(ctrl, addr);
         exp_lat = mis ? 1 : 2 + dly;
         total++; if (r.gw !== 0 || r.lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_timing got gw=%0d lat=%0d exp gw=0 lat=%0d", n, r.gw, r.lat, exp_lat); end
         total++; if (r.en_seen !== !mis || r.mis !== mis || r.other_valid !== 0) begin bad++; $display("FAIL rnd%0d_flags got en=%b mis=%b other=%b exp en=%b mis=%b other=0", n, r.en_seen, r.mis, r.other_valid, !mis, mis); end
         if (!mis) begin
            total++; if (r.addr !== {addr[31:2], 2'b00} || r.we !== we || r.held !== 1) begin bad++; $display("FAIL rnd%0d_req got addr=%h we=%b held=%b exp addr=%h we=%b held=1", n, r.addr, r.we, r.held, {addr[31:2], 2'b00}, we); end
            total++; if (r.be !== m_be(we, ctrl, addr)) begin bad++; $display("FAIL rnd%0d_be got=%b exp=%b", n, r.be, m_be(we, ctrl, addr)); end
            if (we) begin
               total++; if (r.wdata !== m_wdata(ctrl, wd)) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, r.wdata, m_wdata(ctrl, wd)); end
            end
         end
         if (mis || is_if || !we) begin
            exp_rsp = mis ? 32'h0 : (is_if ? rd : m_load(ctrl, addr, rd));
            total++; if (r.rsp !== exp_rsp) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", n, r.rsp, exp_rsp); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw_delay();
      test_lb();
      test_sh();
      test_misalign();
      test_fetch();
      test_starve();
      test_reset_inflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive fetch-loss cycles before fetch is forced to win.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req  input  1  fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr  input  32  fetch word address (bits 1:0 ignored).
REQ-006 SHALL have port if_gnt  output  1  fetch accepted this cycle.
REQ-007 SHALL have port if_valid  output  1  one-cycle pulse; rsp_rdata holds the instruction.
REQ-008 SHALL have port ls_req  input  1  load/store request, held until ls_gnt.
REQ-009 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port ls_ctrl  input  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port ls_addr  input  32  byte address.
REQ-012 SHALL have port ls_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port ls_gnt  output  1  load/store accepted this cycle.
REQ-014 SHALL have port ls_valid  output  1  one-cycle pulse; load data on rsp_rdata, or store done.
REQ-015 SHALL have port ls_misalign  output  1  qualifies ls_valid; access was misaligned and not performed.
REQ-016 SHALL have port rsp_rdata  output  32  response data, qualified by if_valid or ls_valid.
REQ-017 SHALL have ports mem_en/mem_we  output  1 each  memory access strobe / write.
REQ-018 SHALL have ports mem_addr  output  32 (word-aligned); mem_wdata  output  32; mem_be  output  4.
REQ-019 SHALL have ports mem_rdata  input  32; mem_ready  input  1  access complete this cycle.

Function
REQ-020 SHALL implement FSM IDLE, BUSY_IF, BUSY_LS, ERR; at most one access outstanding.
REQ-021 In IDLE, SHALL assert at most one grant, combinationally; the granted request SHALL be latched and the FSM SHALL move to BUSY_IF or BUSY_LS (ERR for misaligned load/store) on the same edge.
REQ-022 Priority SHALL be load/store over fetch, except fetch wins when the starve counter equals STARVE_LIMIT.
REQ-023 The starve counter SHALL increment (saturating) on each IDLE cycle with if_req high and if_gnt low, and SHALL clear on if_gnt.
REQ-024 In BUSY_*, SHALL drive mem_en=1 and hold all latched mem_* values until mem_ready=1, then return to IDLE.
REQ-025 SHALL pulse if_valid or ls_valid exactly one cycle after the mem_ready cycle, with rsp_rdata registered.
REQ-026 Minimum latency SHALL be 2 cycles (grant at N, mem_ready at N+1, valid at N+2); a new grant is allowed in the valid cycle.
REQ-027 Store: mem_be SHALL be 0001/0011/1111 shifted by addr[1:0], and wdata SHALL be replicated to byte/half lanes; mem_we=1.
REQ-028 Load: mem_be=1111; the selected lane SHALL be extracted and sign-extended (B,H) or zero-extended (BU,HU,W).
REQ-029 Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0: ERR SHALL last one cycle with no mem_en, and SHALL pulse ls_valid and ls_misalign with rsp_rdata=0.
REQ-030 An undefined ls_ctrl SHALL be treated as W.
REQ-031 A request dropped before its grant SHALL be ignored; requests during BUSY SHALL wait.

Reset
REQ-032 On rst SHALL immediately enter IDLE, clear the starve counter and drive all outputs 0, including any in-flight access, which is abandoned with no valid.
REQ-033 SHALL accept a grant in the first cycle after rst deasserts.

Structure
REQ-034 The FSM state encoding and size codes (B, H, W, BU, HU) SHALL live in the shared pipeline package.
REQ-035 Lane steering and extension SHALL be one sub-module, mem_lane_align, used for both store and load paths.

Verification
REQ-036 Bench SHALL drive LW at 0x100 with mem_ready delayed 3 cycles and mem_rdata=0xDEADBEEF -> ls_valid at grant+5, rsp_rdata=0xDEADBEEF.
REQ-037 Bench SHALL drive LB at 0x103 with mem_rdata=0x80000000 -> rsp_rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-038 Bench SHALL drive SH at 0x102 with wdata 0x1234 -> mem_be=1100, mem_wdata=0x12341234, mem_we=1.
REQ-039 Bench SHALL drive LW at 0x101 -> no mem_en, ls_valid+ls_misalign at grant+1, rsp_rdata=0.
REQ-040 Bench SHALL hold if_req and ls_req high continuously with STARVE_LIMIT=4 -> 4 ls grants, then 1 if grant, repeating.
REQ-041 Bench SHALL assert rst in BUSY_LS before mem_ready -> no ls_valid; outputs 0; a fresh grant on the first cycle after release.
